// File: rtl/edge_detector_multi.sv
// Multi-channel debounced edge detector: 2-flop sync, per-channel debounce, qualified tick pulses.
// Optional per-channel glitch counters are built only when EDGE_DET_GLITCH_CNT_EN is defined.

module edge_det_chan #(
    parameter int STABLE_COUNT = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_noisy,
    input  logic [1:0]       i_mode,
    input  logic             i_glitch_clr,
    output logic             o_level,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_glitch_cnt
);
    localparam int DW = (STABLE_COUNT < 1) ? 1 : $clog2(STABLE_COUNT + 1);
    localparam logic [DW-1:0] LAST = DW'(STABLE_COUNT - 1);

    logic          r_sync1, r_sync2;
    logic          r_level, r_tick;
    logic [DW-1:0] r_cnt;

    logic w_diff, w_accept, w_qual;
    assign w_diff   = r_sync2 ^ r_level;
    // Accept on the edge where the counter would reach STABLE_COUNT.
    assign w_accept = w_diff && (r_cnt == LAST);
    // New level is the synchronised value: bit0 qualifies rising, bit1 falling.
    assign w_qual   = r_sync2 ? i_mode[0] : i_mode[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_tick  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_noisy;
            r_sync2 <= r_sync1;
            r_tick  <= w_accept && w_qual;
            if (w_accept) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else if (w_diff) begin
                r_cnt   <= r_cnt + 1'b1;
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_tick  = r_tick;

`ifdef EDGE_DET_GLITCH_CNT_EN
    logic             w_reject;
    logic [CNT_W-1:0] r_gcnt;
    // A partial count abandoned because the input fell back to level is a glitch.
    assign w_reject = !w_diff && (r_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_gcnt <= '0;
        else if (i_glitch_clr)
            r_gcnt <= '0;
        else if (w_reject && (r_gcnt != {CNT_W{1'b1}}))
            r_gcnt <= r_gcnt + 1'b1;
    end

    assign o_glitch_cnt = r_gcnt;
`else
    logic w_unused_clr;
    assign w_unused_clr = i_glitch_clr;
    assign o_glitch_cnt = '0;
`endif
endmodule

module edge_detector_multi #(
    parameter int CHANNELS     = 4,
    parameter int STABLE_COUNT = 3,
    parameter int CNT_W        = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       noisy_in,
    input  logic [2*CHANNELS-1:0]     edge_mode,
    input  logic                      glitch_clr,
    output logic [CHANNELS-1:0]       level,
    output logic [CHANNELS-1:0]       tick,
    output logic [CHANNELS*CNT_W-1:0] glitch_cnt
);
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        edge_det_chan #(
            .STABLE_COUNT(STABLE_COUNT),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .i_noisy     (noisy_in[c]),
            .i_mode      (edge_mode[2*c +: 2]),
            .i_glitch_clr(glitch_clr),
            .o_level     (level[c]),
            .o_tick      (tick[c]),
            .o_glitch_cnt(glitch_cnt[c*CNT_W +: CNT_W])
        );
    end
endmodule

// File: doc/edge_detector_multi.md
EDGE_DETECTOR_MULTI -- requirements
Module: edge_detector_multi

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, 1..32.
REQ-002 Parameter STABLE_COUNT, default 3: consecutive cycles a new level must persist before it is accepted, minimum 1.
REQ-003 Parameter CNT_W, default 8: width of each per-channel glitch counter, minimum 1.
REQ-004 clk  input  1: single clock, all state on rising edge.
REQ-005 rst  input  1: reset, asynchronous, active-high.
REQ-006 noisy_in  input  CHANNELS: raw asynchronous inputs, bit c = channel c.
REQ-007 edge_mode  input  2*CHANNELS: bits [2c+1:2c] select channel c mode: 00 none, 01 rising, 10 falling, 11 both.
REQ-008 glitch_clr  input  1: synchronous clear of all glitch counters.
REQ-009 level  output  CHANNELS: debounced stable level per channel.
REQ-010 tick  output  CHANNELS: one-cycle pulse per qualified edge.
REQ-011 glitch_cnt  output  CHANNELS*CNT_W: channel c count in bits [c*CNT_W+CNT_W-1 : c*CNT_W].

Function
REQ-012 Each channel SHALL pass noisy_in through a 2-flop synchroniser before any other logic.
REQ-013 Each channel SHALL hold a debounce counter of width $clog2(STABLE_COUNT+1); it increments each cycle the synchronised value differs from level and clears to 0 on any cycle they match.
REQ-014 level[c] SHALL toggle on the edge at which the counter would reach STABLE_COUNT; the counter clears on that same edge.
REQ-015 Latency: input constant and different from level from before edge E0 -> level and tick update at edge E0+STABLE_COUNT+1 (E4 for STABLE_COUNT=3).
REQ-016 tick[c] SHALL be registered, high for exactly the one cycle following a level[c] change, and only when edge_mode[c] permits that direction (rising 0->1, falling 1->0).
REQ-017 Mode 00 SHALL suppress tick while debounce and level continue to operate.
REQ-018 A edge_mode change SHALL affect only tick qualification from the next edge; debounce state is unaffected.
REQ-019 A pulse whose synchronised value returns to level with the counter nonzero and below STABLE_COUNT SHALL be rejected: no level change, no tick.
REQ-020 Channels SHALL be fully independent; simultaneous events on several channels each produce their own tick in the same cycle.
REQ-021 Each glitch counter SHALL saturate at 2^CNT_W-1, never wrap.
REQ-022 glitch_clr SHALL take priority over a same-cycle increment: result 0.

Reset
REQ-023 rst SHALL asynchronously force synchronisers, debounce counters, level, tick and glitch_cnt to 0.
REQ-024 After rst release, a channel held high SHALL be debounced as a fresh rising edge: tick at E0+STABLE_COUNT+1 if mode permits rising.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count with no tick produced.

Configuration
REQ-026 Macro EDGE_DET_GLITCH_CNT_EN defined: each rejected pulse (REQ-019) SHALL increment that channel's glitch counter by 1.
REQ-027 Macro undefined: no counter logic, glitch_cnt tied to 0, glitch_clr ignored; all ports still present.

Verification (CHANNELS=4, STABLE_COUNT=3, 10 ns clock unless stated)
REQ-028 ch0 mode 01, 150 ns high pulse repeated every 4 us -> one tick per pulse at E0+4; level high 15 cycles; no tick on falling edges.
REQ-029 ch0 mode 01, 20 ns glitches between valid pulses -> no tick, level stays 0; with macro glitch_cnt ch0 +1 per glitch (3 after 3 glitches).
REQ-030 ch1 mode 11, 150 ns pulse -> two ticks 15 cycles apart; ch2 mode 10 same stimulus -> single tick on falling edge only.
REQ-031 CNT_W=2, macro defined, 5 glitches on ch3 -> glitch_cnt ch3 = 3; glitch_clr coinciding with a 6th rejection -> 0.
REQ-032 Input high on ch0, rst asserted at E2 -> all outputs 0 immediately, no tick; rst released, input held high -> tick at E0+4 after release.
REQ-033 Simultaneous 150 ns pulses on all four channels, mode 01 -> tick = 4'b1111 for exactly one cycle.
